// File: rtl/test_result_collector.sv
// rtl/test_result_collector.sv - reduces per-bench fail/finish flags to one sticky pair with a cycle watchdog
// RUN accumulates flags and counts cycles; DONE freezes everything until reset.
module test_result_collector #(
  parameter int NUM_TESTS = 4,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_TESTS-1:0] test_fail,
  input  logic [NUM_TESTS-1:0] test_finish,
  output logic                 fail,
  output logic                 finish,
  output logic                 timeout,
  output logic [NUM_TESTS-1:0] done_mask,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [CNT_W-1:0]     cycles
);

  typedef enum logic {S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 fail_q, fail_d;
  logic                 finish_q, finish_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_TESTS-1:0] done_mask_q, done_mask_d;
  logic [NUM_TESTS-1:0] fail_mask_q, fail_mask_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;

  logic [NUM_TESTS-1:0] done_acc;
  logic [NUM_TESTS-1:0] fail_acc;
  logic                 all_done;
  logic                 wd_hit;

  // Same-edge finish bits count toward all_done, so all_done beats the watchdog.
  assign done_acc = done_mask_q | test_finish;
  assign fail_acc = fail_mask_q | test_fail;
  assign all_done = &done_acc;
  assign wd_hit   = !all_done && (cycles_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      fail_q      <= 1'b0;
      finish_q    <= 1'b0;
      timeout_q   <= 1'b0;
      done_mask_q <= '0;
      fail_mask_q <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      fail_q      <= fail_d;
      finish_q    <= finish_d;
      timeout_q   <= timeout_d;
      done_mask_q <= done_mask_d;
      fail_mask_q <= fail_mask_d;
      cycles_q    <= cycles_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fail_d      = fail_q;
    finish_d    = finish_q;
    timeout_d   = timeout_q;
    done_mask_d = done_mask_q;
    fail_mask_d = fail_mask_q;
    cycles_d    = cycles_q;
    if (state_q == S_RUN) begin
      cycles_d    = cycles_q + CNT_W'(1);
      done_mask_d = done_acc;
      fail_mask_d = fail_acc;
      fail_d      = fail_q | (|test_fail);
      if (all_done) begin
        state_d  = S_DONE;
        finish_d = 1'b1;
      end else if (wd_hit) begin
        state_d   = S_DONE;
        finish_d  = 1'b1;
        timeout_d = 1'b1;
        fail_d    = 1'b1;
      end
    end
  end

  always_comb begin
    fail      = fail_q;
    finish    = finish_q;
    timeout   = timeout_q;
    done_mask = done_mask_q;
    fail_mask = fail_mask_q;
    cycles    = cycles_q;
  end

endmodule

// File: tb/tb_test_result_collector.sv
// tb/tb_test_result_collector.sv - directed self-checking bench for test_result_collector
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
module tb_test_result_collector;

  localparam int NT = 4;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          clock;
  logic          reset;
  logic [NT-1:0] test_fail;
  logic [NT-1:0] test_finish;
  logic          fail;
  logic          finish;
  logic          timeout;
  logic [NT-1:0] done_mask;
  logic [NT-1:0] fail_mask;
  logic [CW-1:0] cycles;

  int n_cmp = 0;
  int n_err = 0;

  test_result_collector #(.NUM_TESTS(NT), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .test_fail  (test_fail),
    .test_finish(test_finish),
    .fail       (fail),
    .finish     (finish),
    .timeout    (timeout),
    .done_mask  (done_mask),
    .fail_mask  (fail_mask),
    .cycles     (cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic f, input logic fin, input logic to,
                           input logic [NT-1:0] dm, input logic [NT-1:0] fm, input logic [CW-1:0] cy);
    check({tag, ".fail"},      32'(fail),      32'(f));
    check({tag, ".finish"},    32'(finish),    32'(fin));
    check({tag, ".timeout"},   32'(timeout),   32'(to));
    check({tag, ".done_mask"}, 32'(done_mask), 32'(dm));
    check({tag, ".fail_mask"}, 32'(fail_mask), 32'(fm));
    check({tag, ".cycles"},    32'(cycles),    32'(cy));
  endtask

  // One rising edge with the given inputs, then inputs return to 0.
  task automatic cyc(input logic [NT-1:0] fin, input logic [NT-1:0] fl);
    test_finish = fin;
    test_fail   = fl;
    @(negedge clock);
    test_finish = '0;
    test_fail   = '0;
  endtask

  // Called on a falling edge; asserts reset between edges and checks the asynchronous clear.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_all(tag, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset       = 1'b1;
    test_fail   = '0;
    test_finish = '0;
    @(negedge clock);
    @(negedge clock);
    check_all("reset", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd0);
    reset = 1'b0;

    // All pass: finishes at cycles 3, 5, 5, 9.
    for (int c = 0; c <= 9; c++) begin
      cyc((c == 3) ? 4'b0001 : (c == 5) ? 4'b0110 : (c == 9) ? 4'b1000 : 4'b0000, 4'b0000);
      if (c == 3) check("pass.latency_dm", 32'(done_mask), 32'h1);
      if (c == 8) check_all("pass.pre", 1'b0, 1'b0, 1'b0, 4'b0111, 4'b0000, 16'd9);
    end
    check_all("pass.done", 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 16'd10);
    for (int i = 0; i < 5; i++) cyc(4'b0000, 4'b0000);
    check("pass.frozen_cycles", 32'(cycles), 32'd10);

    // Single failure on bench 2.
    do_reset("rst1");
    for (int c = 0; c <= 6; c++) begin
      cyc((c == 6) ? 4'b1111 : 4'b0000, (c == 4) ? 4'b0100 : 4'b0000);
      if (c == 3) check("fail1.before", 32'(fail), 32'd0);
      if (c == 4) check_all("fail1.hit", 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 16'd5);
    end
    check_all("fail1.done", 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0100, 16'd7);

    // Watchdog: only benches 0 and 1 ever finish.
    do_reset("rst2");
    for (int c = 0; c <= 15; c++) begin
      cyc((c == 2) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000, 4'b0000);
      if (c == 14) check_all("to.pre", 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0000, 16'd15);
    end
    check_all("to.hit", 1'b1, 1'b1, 1'b1, 4'b0011, 4'b0000, 16'd16);
    for (int i = 0; i < 3; i++) cyc(4'b1111, 4'b0000);
    check_all("to.hold", 1'b1, 1'b1, 1'b1, 4'b0011, 4'b0000, 16'd16);

    // Race: last finish lands exactly on the watchdog edge.
    do_reset("rst3");
    for (int c = 0; c <= 15; c++)
      cyc((c == 1) ? 4'b0111 : (c == 15) ? 4'b1000 : 4'b0000, 4'b0000);
    check_all("race", 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 16'd16);

    // Late fail pulses after DONE are ignored.
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0000, 4'b1111);
      check("late.fail", 32'(fail), 32'd0);
      check("late.fail_mask", 32'(fail_mask), 32'd0);
    end
    check("late.cycles", 32'(cycles), 32'd16);

    // Asynchronous reset mid-run.
    do_reset("rst4");
    for (int c = 0; c <= 6; c++) cyc((c == 2) ? 4'b0011 : 4'b0000, 4'b0000);
    check_all("mid.pre", 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0000, 16'd7);
    do_reset("mid.async");
    check("mid.restart0", 32'(cycles), 32'd0);
    cyc(4'b0000, 4'b0000);
    check_all("mid.restart1", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
